// File: rtl/rv32i_pkg.sv
// Shared RV32I writeback types: source-select encoding, load funct3 codes
// and the forwarding history entry layout.
package rv32i_pkg;

  localparam int RV_XLEN = 32;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_ILL = 2'd3
  } wb_sel_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // One retired writeback held for forwarding ("reg" is a keyword, hence rd).
  typedef struct packed {
    logic               en;
    logic [4:0]         rd;
    logic [RV_XLEN-1:0] data;
  } wb_hist_t;

endpackage

// File: rtl/rv32i_load_align.sv
// Load data alignment: shifts the raw memory word down by the byte offset,
// extends according to the load type, and flags misaligned or unknown loads.
module rv32i_load_align
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o,
  output logic            misalign_o,
  output logic            illegal_o
);

  logic [XLEN-1:0] shifted;

  // Shift by the byte offset, then extend and check alignment per load type.
  always_comb begin
    shifted    = rdata_i >> {offset_i, 3'b000};
    data_o     = shifted;
    misalign_o = 1'b0;
    illegal_o  = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LBU: data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LH: begin
        data_o     = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
        misalign_o = offset_i[0];
      end
      F3_LHU: begin
        data_o     = {{(XLEN-16){1'b0}}, shifted[15:0]};
        misalign_o = offset_i[0];
      end
      F3_LW:   misalign_o = |offset_i;
      default: illegal_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_wb_stage.sv
// RV32I writeback stage: selects the writeback source, registers it for the
// register file, keeps a short forwarding history and counts retirements.
module rv32i_wb_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int HIST_DEPTH = 2,
  parameter int CNT_W      = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  input  logic                       stall_in,
  input  logic                       flush_in,
  input  logic                       wb_en_in,
  input  logic [4:0]                 wb_reg_in,
  input  logic [1:0]                 wb_sel_in,
  input  logic [2:0]                 ld_funct3_in,
  input  logic [XLEN-1:0]            pc_in,
  input  logic [XLEN-1:0]            iw_in,
  input  logic [XLEN-1:0]            alu_in,
  input  logic [XLEN-1:0]            mem_rdata_in,
  output logic                       valid_out,
  output logic                       wb_en_out,
  output logic [4:0]                 wb_reg_out,
  output logic [XLEN-1:0]            wb_data_out,
  output logic [XLEN-1:0]            pc_out,
  output logic [XLEN-1:0]            iw_out,
  output logic                       misalign_err,
  output logic                       illegal_sel_err,
  output logic [HIST_DEPTH-1:0]      df_wb_enable,
  output logic [5*HIST_DEPTH-1:0]    df_wb_reg,
  output logic [XLEN*HIST_DEPTH-1:0] df_wb_data,
  output logic [CNT_W-1:0]           retire_count
);

  wb_sel_t         sel;
  logic [XLEN-1:0] ld_data;
  logic            ld_mis, ld_ill;
  logic            cap_vld, is_mis, is_ill, cap_en;
  logic [XLEN-1:0] cap_data;

  logic            valid_q, valid_d;
  logic            wb_en_q, wb_en_d;
  logic [4:0]      wb_reg_q, wb_reg_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] iw_q, iw_d;
  logic            mis_q, mis_d;
  logic            ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  wb_hist_t        hist_q [HIST_DEPTH];
  wb_hist_t        hist_d [HIST_DEPTH];

  assign sel = wb_sel_t'(wb_sel_in);

  rv32i_load_align #(.XLEN(XLEN)) u_align (
    .funct3_i   (ld_funct3_in),
    .offset_i   (alu_in[1:0]),
    .rdata_i    (mem_rdata_in),
    .data_o     (ld_data),
    .misalign_o (ld_mis),
    .illegal_o  (ld_ill)
  );

  // Decode the incoming instruction into its writeback data and qualifiers.
  always_comb begin
    cap_vld  = valid_in & ~flush_in;
    is_ill   = (sel == WB_ILL) | ((sel == WB_MEM) & ld_ill);
    is_mis   = (sel == WB_MEM) & ld_mis;
    cap_en   = cap_vld & wb_en_in & (wb_reg_in != 5'd0) & ~is_mis & ~is_ill;
    case (sel)
      WB_ALU:  cap_data = alu_in;
      WB_MEM:  cap_data = ld_data;
      WB_PC4:  cap_data = pc_in + XLEN'(4);
      default: cap_data = alu_in;
    endcase
  end

  // Next state: hold everything on stall, otherwise capture; history and
  // counter advance only when a valid instruction is captured.
  always_comb begin
    valid_d   = valid_q;
    wb_en_d   = wb_en_q;
    wb_reg_d  = wb_reg_q;
    wb_data_d = wb_data_q;
    pc_d      = pc_q;
    iw_d      = iw_q;
    mis_d     = mis_q;
    ill_d     = ill_q;
    cnt_d     = cnt_q;
    hist_d    = hist_q;
    if (!stall_in) begin
      valid_d   = cap_vld;
      wb_en_d   = cap_en;
      wb_reg_d  = wb_reg_in;
      wb_data_d = cap_data;
      pc_d      = pc_in;
      iw_d      = iw_in;
      mis_d     = cap_vld & is_mis;
      ill_d     = cap_vld & is_ill;
      if (cap_vld) begin
        cnt_d = cnt_q + CNT_W'(1);
        for (int k = HIST_DEPTH - 1; k > 0; k--) begin
          hist_d[k] = hist_q[k-1];
        end
        hist_d[0] = '{en: cap_en, rd: wb_reg_in, data: RV_XLEN'(cap_data)};
      end
    end
  end

  // Stage, history and counter registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_reg_q  <= '0;
      wb_data_q <= '0;
      pc_q      <= '0;
      iw_q      <= '0;
      mis_q     <= 1'b0;
      ill_q     <= 1'b0;
      cnt_q     <= '0;
      for (int k = 0; k < HIST_DEPTH; k++) begin
        hist_q[k] <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      wb_en_q   <= wb_en_d;
      wb_reg_q  <= wb_reg_d;
      wb_data_q <= wb_data_d;
      pc_q      <= pc_d;
      iw_q      <= iw_d;
      mis_q     <= mis_d;
      ill_q     <= ill_d;
      cnt_q     <= cnt_d;
      hist_q    <= hist_d;
    end
  end

  assign valid_out       = valid_q;
  assign wb_en_out       = wb_en_q;
  assign wb_reg_out      = wb_reg_q;
  assign wb_data_out     = wb_data_q;
  assign pc_out          = pc_q;
  assign iw_out          = iw_q;
  assign misalign_err    = mis_q;
  assign illegal_sel_err = ill_q;
  assign retire_count    = cnt_q;

  for (genvar k = 0; k < HIST_DEPTH; k++) begin : g_df
    assign df_wb_enable[k]           = hist_q[k].en;
    assign df_wb_reg[5*k +: 5]       = hist_q[k].rd;
    assign df_wb_data[XLEN*k +: XLEN] = XLEN'(hist_q[k].data);
  end

endmodule

// File: tb/tb_rv32i_wb_stage.sv
// Testbench for rv32i_wb_stage: directed vector table, stall/flush/history
// sequence, randomized traffic against a behavioural model, async reset.
module tb_rv32i_wb_stage;

  localparam int XLEN = 32;
  localparam int HD   = 2;
  localparam int CW   = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            valid_in, stall_in, flush_in, wb_en_in;
  logic [4:0]      wb_reg_in;
  logic [1:0]      wb_sel_in;
  logic [2:0]      ld_funct3_in;
  logic [XLEN-1:0] pc_in, iw_in, alu_in, mem_rdata_in;
  logic            valid_out, wb_en_out, misalign_err, illegal_sel_err;
  logic [4:0]      wb_reg_out;
  logic [XLEN-1:0] wb_data_out, pc_out, iw_out;
  logic [HD-1:0]   df_wb_enable;
  logic [5*HD-1:0] df_wb_reg;
  logic [XLEN*HD-1:0] df_wb_data;
  logic [CW-1:0]   retire_count;

  rv32i_wb_stage #(.XLEN(XLEN), .HIST_DEPTH(HD), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .stall_in(stall_in),
    .flush_in(flush_in), .wb_en_in(wb_en_in), .wb_reg_in(wb_reg_in),
    .wb_sel_in(wb_sel_in), .ld_funct3_in(ld_funct3_in), .pc_in(pc_in),
    .iw_in(iw_in), .alu_in(alu_in), .mem_rdata_in(mem_rdata_in),
    .valid_out(valid_out), .wb_en_out(wb_en_out), .wb_reg_out(wb_reg_out),
    .wb_data_out(wb_data_out), .pc_out(pc_out), .iw_out(iw_out),
    .misalign_err(misalign_err), .illegal_sel_err(illegal_sel_err),
    .df_wb_enable(df_wb_enable), .df_wb_reg(df_wb_reg),
    .df_wb_data(df_wb_data), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { bit en; bit [4:0] rd; bit [31:0] data; } hent_t;
  hent_t     mh[$];
  bit        m_valid, m_en, m_mis, m_ill;
  bit [4:0]  m_reg;
  bit [31:0] m_data, m_pc, m_iw, m_cnt;

  function automatic void ref_eval(input bit [1:0] sel, input bit [2:0] f3,
                                   input bit [31:0] alu, input bit [31:0] rdata,
                                   input bit [31:0] pc, output bit [31:0] d,
                                   output bit mis, output bit ill);
    int unsigned off;
    bit [31:0] w, b, h;
    off = alu % 4;
    w   = rdata >> (8 * off);
    b   = w % 256;
    h   = w % 65536;
    d = 0; mis = 0; ill = 0;
    case (sel)
      2'd0: d = alu;
      2'd2: d = pc + 4;
      2'd3: ill = 1;
      default: begin
        case (f3)
          3'b000: d = (b < 128) ? b : b + 32'hFFFF_FF00;
          3'b100: d = b;
          3'b001: begin d = (h < 32768) ? h : h + 32'hFFFF_0000; mis = (off % 2) != 0; end
          3'b101: begin d = h; mis = (off % 2) != 0; end
          3'b010: begin d = w; mis = off != 0; end
          default: ill = 1;
        endcase
      end
    endcase
  endfunction

  task automatic model_reset();
    hent_t z;
    z = '{0, 0, 0};
    m_valid = 0; m_en = 0; m_mis = 0; m_ill = 0;
    m_reg = 0; m_data = 0; m_pc = 0; m_iw = 0; m_cnt = 0;
    mh.delete();
    for (int i = 0; i < HD; i++) mh.push_back(z);
  endtask

  task automatic model_clock();
    bit v, mis, ill;
    bit [31:0] d;
    if (!stall_in) begin
      v = valid_in & ~flush_in;
      ref_eval(wb_sel_in, ld_funct3_in, alu_in, mem_rdata_in, pc_in, d, mis, ill);
      m_valid = v;
      m_en    = v & wb_en_in & (wb_reg_in != 0) & !mis & !ill;
      m_mis   = v & mis;
      m_ill   = v & ill;
      m_reg   = wb_reg_in;
      m_data  = d;
      m_pc    = pc_in;
      m_iw    = iw_in;
      if (v) begin
        m_cnt++;
        mh.push_front('{m_en, m_reg, m_data});
        void'(mh.pop_back());
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, valid_out, m_valid);
    chk({tag, ".wb_en"}, wb_en_out, m_en);
    chk({tag, ".mis"}, misalign_err, m_mis);
    chk({tag, ".ill"}, illegal_sel_err, m_ill);
    chk({tag, ".cnt"}, retire_count, m_cnt);
    if (m_valid) begin
      chk({tag, ".reg"}, wb_reg_out, m_reg);
      chk({tag, ".pc"}, pc_out, m_pc);
      chk({tag, ".iw"}, iw_out, m_iw);
      if (!m_mis && !m_ill) chk({tag, ".data"}, wb_data_out, m_data);
    end
    for (int k = 0; k < HD; k++) begin
      chk($sformatf("%s.df_en%0d", tag, k), df_wb_enable[k], mh[k].en);
      chk($sformatf("%s.df_reg%0d", tag, k), df_wb_reg[5*k +: 5], mh[k].rd);
      if (mh[k].en) chk($sformatf("%s.df_data%0d", tag, k), df_wb_data[32*k +: 32], mh[k].data);
    end
  endtask

  task automatic drive(input bit v, input bit st, input bit fl, input bit en,
                       input bit [4:0] rd, input bit [1:0] sel, input bit [2:0] f3,
                       input bit [31:0] alu, input bit [31:0] rdata, input bit [31:0] pc);
    valid_in = v; stall_in = st; flush_in = fl; wb_en_in = en;
    wb_reg_in = rd; wb_sel_in = sel; ld_funct3_in = f3;
    alu_in = alu; mem_rdata_in = rdata; pc_in = pc; iw_in = pc ^ 32'h0000_0013;
  endtask

  // One clock: edge, model update, sample 1 time unit later, back to negedge.
  task automatic step(input string tag);
    @(posedge clk);
    model_clock();
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit [1:0] sel; bit [2:0] f3; bit [4:0] rd; bit [31:0] alu, rdata, pc;
    bit x_en, x_mis, x_ill, x_chkd; bit [31:0] x_data;
  } vec_t;
  vec_t tbl[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{2'd0, 3'b000, 5'd5, 32'h1234_5678, 32'h0,         32'h0,         1, 0, 0, 1, 32'h1234_5678};
    tbl[1]  = '{2'd0, 3'b000, 5'd0, 32'h1234_5678, 32'h0,         32'h0,         0, 0, 0, 1, 32'h1234_5678};
    tbl[2]  = '{2'd1, 3'b000, 5'd7, 32'h0000_1002, 32'h80FF_7F01, 32'h0,         1, 0, 0, 1, 32'hFFFF_FFFF};
    tbl[3]  = '{2'd1, 3'b100, 5'd7, 32'h0000_1002, 32'h80FF_7F01, 32'h0,         1, 0, 0, 1, 32'h0000_00FF};
    tbl[4]  = '{2'd1, 3'b001, 5'd7, 32'h0000_1002, 32'h80FF_7F01, 32'h0,         1, 0, 0, 1, 32'hFFFF_80FF};
    tbl[5]  = '{2'd1, 3'b101, 5'd7, 32'h0000_1000, 32'h80FF_7F01, 32'h0,         1, 0, 0, 1, 32'h0000_7F01};
    tbl[6]  = '{2'd1, 3'b010, 5'd7, 32'h0000_1000, 32'h80FF_7F01, 32'h0,         1, 0, 0, 1, 32'h80FF_7F01};
    tbl[7]  = '{2'd1, 3'b010, 5'd7, 32'h0000_1001, 32'h80FF_7F01, 32'h0,         0, 1, 0, 0, 32'h0};
    tbl[8]  = '{2'd3, 3'b000, 5'd7, 32'h0000_0055, 32'h0,         32'h0,         0, 0, 1, 0, 32'h0};
    tbl[9]  = '{2'd2, 3'b000, 5'd1, 32'h0,         32'h0,         32'hFFFF_FFFC, 1, 0, 0, 1, 32'h0000_0000};
    tbl[10] = '{2'd2, 3'b000, 5'd1, 32'h0,         32'h0,         32'h0000_0100, 1, 0, 0, 1, 32'h0000_0104};
    tbl[11] = '{2'd1, 3'b011, 5'd7, 32'h0000_1000, 32'h80FF_7F01, 32'h0,         0, 0, 1, 0, 32'h0};

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b1;

    // Directed table: one valid instruction per cycle.
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 0, 1, tbl[i].rd, tbl[i].sel, tbl[i].f3, tbl[i].alu, tbl[i].rdata, tbl[i].pc);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.t_en", i), wb_en_out, tbl[i].x_en);
      chk($sformatf("vec%0d.t_mis", i), misalign_err, tbl[i].x_mis);
      chk($sformatf("vec%0d.t_ill", i), illegal_sel_err, tbl[i].x_ill);
      chk($sformatf("vec%0d.t_cnt", i), retire_count, i + 1);
      if (tbl[i].x_chkd) chk($sformatf("vec%0d.t_data", i), wb_data_out, tbl[i].x_data);
    end

    // History, stall and flush.
    drive(1, 0, 0, 1, 5'd1, 2'd0, 0, 32'hA, 0, 32'h200);
    step("hist_r1");
    drive(1, 0, 0, 1, 5'd2, 2'd0, 0, 32'hB, 0, 32'h204);
    step("hist_r2");
    chk("hist.e0_reg", df_wb_reg[4:0], 5'd2);
    chk("hist.e0_data", df_wb_data[31:0], 32'hB);
    chk("hist.e1_reg", df_wb_reg[9:5], 5'd1);
    chk("hist.e1_data", df_wb_data[63:32], 32'hA);
    chk("hist.en", df_wb_enable, 2'b11);
    chk("hist.cnt", retire_count, 14);
    drive(1, 1, 0, 1, 5'd3, 2'd0, 0, 32'hC, 0, 32'h208);
    step("stall");
    chk("stall.reg", wb_reg_out, 5'd2);
    chk("stall.data", wb_data_out, 32'hB);
    chk("stall.e0_reg", df_wb_reg[4:0], 5'd2);
    chk("stall.cnt", retire_count, 14);
    drive(1, 0, 1, 1, 5'd4, 2'd0, 0, 32'hD, 0, 32'h20C);
    step("flush");
    chk("flush.valid", valid_out, 1'b0);
    chk("flush.wb_en", wb_en_out, 1'b0);
    chk("flush.e0_reg", df_wb_reg[4:0], 5'd2);
    chk("flush.e1_data", df_wb_data[63:32], 32'hA);
    chk("flush.cnt", retire_count, 14);
    drive(1, 1, 1, 1, 5'd6, 2'd0, 0, 32'hE, 0, 32'h210);
    step("stall_flush");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 2),
            ($urandom_range(0, 9) < 1), $urandom_range(0, 1),
            5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
      step($sformatf("rnd%0d", i));
    end

    // Asynchronous reset between edges after a few writebacks.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, 5'(i + 8), 2'd0, 0, 32'h100 + i, 0, 32'h300);
      step($sformatf("pre_rst%0d", i));
    end
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.cnt0", retire_count, 0);
    chk("async_rst.df_data", df_wb_data, 64'h0);
    chk("async_rst.wb_data", wb_data_out, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
